// File: rtl/spi_pkg.sv
// Shared constants and FSM state encoding for the register-mapped SPI link.
// Frame = {rw, addr[6:0]} header followed by an 8-bit payload, MSB first.
package spi_pkg;

    localparam int   SPI_HDR_W   = 8;
    localparam int   SPI_PAY_W   = 8;
    localparam int   SPI_ADDR_W  = 7;
    localparam int   SPI_PKT_W   = 16;
    localparam logic SPI_RW_READ = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_mst_state_t;

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period tick generator: o_tick is high on the last clk cycle of every
// CLK_DIV-cycle phase while enabled; held at zero while cleared or disabled.
module spi_sclk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(CLK_DIV - 1));
    assign o_tick = i_en && w_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 host: one 16-bit frame per accepted start, optional 8-bit read
// capture on MISO. Every output is driven straight from a register.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  rw,
    input  logic [SPI_ADDR_W-1:0] addr,
    input  logic [SPI_PAY_W-1:0]  wdata,
    output logic                  busy,
    output logic                  done,
    output logic [SPI_PAY_W-1:0]  rdata,
    output logic                  SCLK,
    output logic                  SSB,
    output logic                  MOSI,
    input  logic                  MISO
);

    if (CLK_DIV < 3) begin : g_bad_clk_div
        $error("spi_master: CLK_DIV must be >= 3");
    end

    localparam logic [4:0] BIT_LAST = 5'd15;

    spi_mst_state_t         r_state;
    logic [4:0]             r_bit;
    logic [SPI_PKT_W-1:0]   r_tx;
    logic [SPI_PAY_W-1:0]   r_rx;
    logic                   r_rw;
    logic                   r_gap2;
    logic                   w_tick;
    logic                   w_div_clr;
    logic                   w_div_en;

    // The divider free-runs across back-to-back phases; only IDLE parks it.
    assign w_div_clr = (r_state == IDLE);
    assign w_div_en  = !w_div_clr;

    spi_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_div_en),
        .i_clr   (w_div_clr),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_bit   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_rw    <= 1'b0;
            r_gap2  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rdata   <= '0;
            SCLK    <= 1'b0;
            SSB     <= 1'b1;
            MOSI    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_tx    <= {rw, addr, (rw == SPI_RW_READ) ? 8'h00 : wdata};
                        r_rw    <= rw;
                        r_rx    <= '0;
                        r_bit   <= '0;
                        MOSI    <= rw;
                        SSB     <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_tick) begin
                        SCLK    <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_tick) begin
                        if (SCLK) begin
                            // End of high phase: sample MISO, present next bit.
                            SCLK <= 1'b0;
                            if (r_rw == SPI_RW_READ && r_bit >= 5'(SPI_HDR_W)) begin
                                r_rx <= {r_rx[SPI_PAY_W-2:0], MISO};
                            end
                            r_tx <= {r_tx[SPI_PKT_W-2:0], 1'b0};
                            MOSI <= (r_bit == BIT_LAST) ? 1'b0 : r_tx[SPI_PKT_W-2];
                        end else if (r_bit == BIT_LAST) begin
                            r_state <= HOLD;
                        end else begin
                            r_bit <= r_bit + 5'd1;
                            SCLK  <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        SSB    <= 1'b1;
                        done   <= 1'b1;
                        r_gap2 <= 1'b0;
                        if (r_rw == SPI_RW_READ) begin
                            rdata <= r_rx;
                        end
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    // Two divider phases give the 2*CLK_DIV SSB-high guard time.
                    if (w_tick) begin
                        if (r_gap2) begin
                            busy    <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_gap2 <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: bit-level slave model, table of frames
// (fixed plus $urandom), and hand sequences for reset, overlap and streaming.
module tb_spi_master;

    localparam int CD = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       busy, done, SCLK, SSB, MOSI;
    logic [7:0] rdata;
    logic       MISO = 1'b0;

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(CD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .rw      (rw),
        .addr    (addr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .rdata   (rdata),
        .SCLK    (SCLK),
        .SSB     (SSB),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave model: shifts MOSI in on each SCLK rise, drives MISO from a
    // 16-bit response word MSB-first, changing only while SCLK is low.
    int         rises = 0;
    int         rise_cyc [40];
    logic [15:0] mosi_word = '0;
    logic [15:0] miso_word = '0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic [7:0] done_rdata = '0;
    int         ssb_fall_q [$];
    int         ssb_rise_q [$];
    logic       prev_sclk = 1'b0;
    logic       prev_ssb = 1'b1;

    always @(negedge clk) begin
        if (prev_ssb && !SSB) begin
            rises = 0;
            mosi_word = '0;
            MISO = miso_word[15];
            ssb_fall_q.push_back(cyc);
        end
        if (!prev_ssb && SSB) ssb_rise_q.push_back(cyc);
        if (!SSB && SCLK && !prev_sclk) begin
            if (rises < 40) rise_cyc[rises] = cyc;
            rises++;
            mosi_word = {mosi_word[14:0], MOSI};
        end
        if (!SSB && !SCLK && prev_sclk && rises < 16) MISO = miso_word[15 - rises];
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_rdata = rdata;
        end
        prev_sclk = SCLK;
        prev_ssb = SSB;
    end

    typedef struct {
        bit        rw;
        bit [6:0]  addr;
        bit [7:0]  wdata;
        bit [7:0]  resp;
        bit [15:0] exp_frame;
        bit [7:0]  exp_rdata;
    } vec_t;

    vec_t       tbl [12];
    logic [7:0] model_rdata = 8'h00;

    // Reference: frame = {rw, addr, payload}; reads return the slave byte,
    // writes keep the previous read result.
    function automatic vec_t mk(input bit r, input bit [6:0] a, input bit [7:0] w,
                                input bit [7:0] resp, input bit [7:0] prev);
        vec_t v;
        v.rw = r;
        v.addr = a;
        v.wdata = w;
        v.resp = resp;
        v.exp_frame = {r, a, (r ? 8'h00 : w)};
        v.exp_rdata = r ? resp : prev;
        return v;
    endfunction

    task automatic wait_idle(input string name, input int t_exp);
        int w;
        w = 0;
        while (busy && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk(name, cyc, t_exp);
    endtask

    task automatic do_frame(input string name, input vec_t v);
        int t0, d0;
        miso_word = {8'h00, v.resp};
        @(negedge clk);
        start = 1'b1;
        rw = v.rw;
        addr = v.addr;
        wdata = v.wdata;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        d0 = done_cnt;
        chk({name, " busy_after_accept"}, busy, 1);
        // Outputs visible after edge T0+n correspond to cycle T0+1+n.
        wait_idle({name, " busy_fall"}, t0 + 36 * CD);
        chk({name, " done_count"}, done_cnt - d0, 1);
        chk({name, " done_time"}, done_cyc, t0 + 34 * CD);
        chk({name, " rises"}, rises, 16);
        chk({name, " first_rise"}, rise_cyc[0], t0 + CD);
        chk({name, " last_rise"}, rise_cyc[15], t0 + 31 * CD);
        chk({name, " mosi_frame"}, mosi_word, v.exp_frame);
        chk({name, " rdata_at_done"}, done_rdata, v.exp_rdata);
        chk({name, " rdata_held"}, rdata, v.exp_rdata);
    endtask

    initial begin
        int t0, d0, nf, w;
        vec_t v;

        repeat (3) @(negedge clk);
        chk("reset SSB", SSB, 1);
        chk("reset SCLK", SCLK, 0);
        chk("reset MOSI", MOSI, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset rdata", rdata, 8'h00);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("idle_reset SSB", SSB, 1);
        chk("idle_reset busy", busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        tbl[0] = mk(1'b0, 7'h02, 8'h03, 8'h00, 8'h00);
        tbl[0].exp_frame = 16'h0203;
        tbl[1] = mk(1'b1, 7'h01, 8'h00, 8'h80, 8'h00);
        tbl[1].exp_frame = 16'h8100;
        tbl[1].exp_rdata = 8'h80;
        model_rdata = 8'h80;
        for (int i = 2; i < 11; i++) begin
            tbl[i] = mk(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), model_rdata);
            model_rdata = tbl[i].exp_rdata;
        end
        tbl[11] = mk(1'b1, 7'h05, 8'hEE, 8'hA5, model_rdata);
        model_rdata = 8'hA5;

        for (int i = 0; i < 12; i++) begin
            do_frame($sformatf("vec%0d", i), tbl[i]);
        end

        // start pulses while busy must be ignored and not queued
        miso_word = 16'h0000;
        @(negedge clk);
        start = 1'b1; rw = 1'b0; addr = 7'h05; wdata = 8'h55;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        start = 1'b1; rw = 1'b1; addr = 7'h7F; wdata = 8'hFF;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_idle("overlap busy_fall", t0 + 36 * CD);
        chk("overlap frame", mosi_word, 16'h0555);
        chk("overlap done_count", done_cnt - d0, 1);
        nf = ssb_fall_q.size();
        repeat (20) @(negedge clk);
        chk("overlap not_queued", ssb_fall_q.size(), nf);
        chk("overlap rdata", rdata, model_rdata);

        // start held high: a new frame on every return to IDLE
        ssb_fall_q.delete();
        ssb_rise_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; rw = 1'b0; addr = 7'h10; wdata = 8'h22;
        repeat (300) @(negedge clk);
        start = 1'b0;
        wait_idle("stream idle", ssb_fall_q.size() > 0 ? ssb_fall_q[$] + 36 * CD : -1);
        chk("stream frames", ssb_fall_q.size(), 3);
        chk("stream dones", done_cnt - d0, 3);
        chk("stream frame", mosi_word, 16'h1022);
        if (ssb_fall_q.size() >= 3 && ssb_rise_q.size() >= 1) begin
            chk("stream restart1", ssb_fall_q[1] - ssb_fall_q[0], 36 * CD + 1);
            chk("stream restart2", ssb_fall_q[2] - ssb_fall_q[1], 36 * CD + 1);
            chk("stream ssb_high_min", (ssb_fall_q[1] - ssb_rise_q[0]) >= 2 * CD, 1);
        end

        // reset in the middle of a read frame
        v = mk(1'b1, 7'h06, 8'h00, 8'h5A, model_rdata);
        do_frame("pre_reset_read", v);
        miso_word = {8'h00, 8'hC3};
        @(negedge clk);
        start = 1'b1; rw = 1'b1; addr = 7'h04; wdata = 8'h00;
        @(negedge clk);
        start = 1'b0;
        d0 = done_cnt;
        w = 0;
        while (rises < 5 && w < 400) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("midreset reached_rise5", rises >= 5, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("midreset SSB", SSB, 1);
        chk("midreset SCLK", SCLK, 0);
        chk("midreset MOSI", MOSI, 0);
        chk("midreset busy", busy, 0);
        chk("midreset rdata", rdata, 8'h00);
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("midreset no_done", done_cnt, d0);
        model_rdata = 8'h00;
        v = mk(1'b0, 7'h03, 8'h01, 8'h00, model_rdata);
        v.exp_frame = 16'h0301;
        do_frame("post_reset_write", v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
